// File: rtl/color_classifier.sv
// color_classifier: classifies an RGB sample against two threshold sets into one-hot red/green/blue/purple/yellow flags.
// Define COLOR_HOLD_EN to require HOLD_CYCLES consecutive matching samples before a flag asserts.
module color_classifier #(
   parameter int WIDTH       = 8,
   parameter int HOLD_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic             red,
   output logic             green,
   output logic             blue,
   output logic             purple,
   output logic             yellow,
   input  logic [WIDTH-1:0] r_signal,
   input  logic [WIDTH-1:0] g_signal,
   input  logic [WIDTH-1:0] b_signal,
   input  logic [WIDTH-1:0] r1_code,
   input  logic [WIDTH-1:0] g1_code,
   input  logic [WIDTH-1:0] b1_code,
   input  logic [WIDTH-1:0] r2_code,
   input  logic [WIDTH-1:0] g2_code,
   input  logic [WIDTH-1:0] b2_code
);
   localparam logic [2:0] CLS_NONE   = 3'd0;
   localparam logic [2:0] CLS_RED    = 3'd1;
   localparam logic [2:0] CLS_GREEN  = 3'd2;
   localparam logic [2:0] CLS_BLUE   = 3'd3;
   localparam logic [2:0] CLS_PURPLE = 3'd4;
   localparam logic [2:0] CLS_YELLOW = 3'd5;
   logic r_hi, r_lo, r_mid, g_hi, g_lo, b_hi, b_lo;
   logic [2:0] cls, shown_cls;
   assign r_hi  = r_signal > r1_code;
   assign r_lo  = r_signal <= r2_code;
   assign r_mid = (r_signal > r2_code) && (r_signal <= r1_code);
   assign g_hi  = g_signal > g2_code;
   assign g_lo  = g_signal <= g1_code;
   assign b_hi  = b_signal > b2_code;
   assign b_lo  = b_signal <= b1_code;
   // Priority chain keeps the flags one-hot even with inconsistent thresholds.
   assign cls = (r_hi  && g_lo && b_lo) ? CLS_RED    :
                (g_hi  && r_lo && b_lo) ? CLS_GREEN  :
                (b_hi  && r_lo && g_lo) ? CLS_BLUE   :
                (b_hi  && r_mid && g_lo) ? CLS_PURPLE :
                (r_hi  && g_hi && b_lo) ? CLS_YELLOW : CLS_NONE;
`ifdef COLOR_HOLD_EN
   localparam logic [7:0] HOLD = 8'(HOLD_CYCLES);
   logic [7:0] cnt;
   logic [2:0] last_cls;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         last_cls <= CLS_NONE;
      end else begin
         cnt      <= (cls == CLS_NONE) ? 8'd0 : (cls != last_cls) ? 8'd1 : (cnt == HOLD) ? HOLD : cnt + 8'd1;
         last_cls <= cls;
      end
   end
   assign shown_cls = (cnt == HOLD) ? last_cls : CLS_NONE;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) shown_cls <= CLS_NONE;
      else     shown_cls <= cls;
   end
`endif
   assign red    = shown_cls == CLS_RED;
   assign green  = shown_cls == CLS_GREEN;
   assign blue   = shown_cls == CLS_BLUE;
   assign purple = shown_cls == CLS_PURPLE;
   assign yellow = shown_cls == CLS_YELLOW;
endmodule

// File: tb/tb_color_classifier.sv
// tb_color_classifier: directed-vector bench for color_classifier; flags viewed as {red,green,blue,purple,yellow}.
module tb_color_classifier;
   localparam logic [4:0] F_R = 5'b10000, F_G = 5'b01000, F_B = 5'b00100, F_P = 5'b00010, F_Y = 5'b00001, F_0 = 5'b00000;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic red, green, blue, purple, yellow;
   logic [7:0] r_signal = '0, g_signal = '0, b_signal = '0;
   logic [7:0] r1_code = 8'h96, g1_code = 8'h32, b1_code = 8'h32;
   logic [7:0] r2_code = 8'h32, g2_code = 8'h96, b2_code = 8'h96;
   logic [4:0] f;
   int errors = 0;
   int checks = 0;
   assign f = {red, green, blue, purple, yellow};
   always #5 clk = ~clk;
   color_classifier #(.WIDTH(8), .HOLD_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .red(red), .green(green), .blue(blue), .purple(purple), .yellow(yellow),
      .r_signal(r_signal), .g_signal(g_signal), .b_signal(b_signal),
      .r1_code(r1_code), .g1_code(g1_code), .b1_code(b1_code),
      .r2_code(r2_code), .g2_code(g2_code), .b2_code(b2_code)
   );
   task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      @(negedge clk);
      r_signal = r;
      g_signal = g;
      b_signal = b;
      @(posedge clk);
      #1;
   endtask
   task automatic set_thresholds(input logic [7:0] r1, g1, b1, r2, g2, b2);
      r1_code = r1; g1_code = g1; b1_code = b1;
      r2_code = r2; g2_code = g2; b2_code = b2;
   endtask
   task automatic test_reset;
      rst = 1'b1;
      r_signal = 8'h97;
      @(posedge clk);
      #1;
      checks++;
      if (f !== F_0) begin errors++; $display("FAIL reset: flags=%b expected %b", f, F_0); end
      @(negedge clk);
      rst = 1'b0;
      r_signal = 8'h00;
      @(posedge clk);
      #1;
   endtask
   task automatic test_primary;
      logic [7:0] rv[3] = '{8'h97, 8'h00, 8'h00};
      logic [7:0] gv[3] = '{8'h00, 8'h97, 8'h00};
      logic [7:0] bv[3] = '{8'h00, 8'h00, 8'h97};
      logic [4:0] ev[3] = '{F_R, F_G, F_B};
      for (int i = 0; i < 3; i++) begin
         drive(rv[i], gv[i], bv[i]);
         checks++;
         if (f !== ev[i]) begin errors++; $display("FAIL primary[%0d]: flags=%b expected %b", i, f, ev[i]); end
      end
   endtask
   task automatic test_mixed;
      drive(8'h33, 8'h00, 8'h97);
      checks++;
      if (f !== F_P) begin errors++; $display("FAIL purple: flags=%b expected %b", f, F_P); end
      drive(8'h97, 8'h97, 8'h00);
      checks++;
      if (f !== F_Y) begin errors++; $display("FAIL yellow: flags=%b expected %b", f, F_Y); end
   endtask
   task automatic test_boundary;
      logic [7:0] rv[5] = '{8'h96, 8'h00, 8'h00, 8'h33, 8'h96};
      logic [7:0] gv[5] = '{8'h00, 8'h96, 8'h00, 8'h00, 8'h96};
      logic [7:0] bv[5] = '{8'h00, 8'h00, 8'h96, 8'h96, 8'h00};
      for (int i = 0; i < 5; i++) begin
         drive(8'h97, 8'h00, 8'h00);
         drive(rv[i], gv[i], bv[i]);
         checks++;
         if (f !== F_0) begin errors++; $display("FAIL boundary[%0d]: flags=%b expected %b", i, f, F_0); end
      end
   endtask
   task automatic test_no_match;
      logic [7:0] rv[3] = '{8'hFF, 8'h00, 8'hFF};
      logic [7:0] gv[3] = '{8'hFF, 8'h00, 8'h7F};
      logic [7:0] bv[3] = '{8'hFF, 8'h00, 8'h00};
      for (int i = 0; i < 3; i++) begin
         drive(8'h00, 8'h97, 8'h00);
         drive(rv[i], gv[i], bv[i]);
         checks++;
         if (f !== F_0) begin errors++; $display("FAIL no_match[%0d]: flags=%b expected %b", i, f, F_0); end
      end
   endtask
   task automatic test_priority;
      set_thresholds(8'h10, 8'h80, 8'h80, 8'h80, 8'h10, 8'h10);
      drive(8'h50, 8'h50, 8'h50);
      checks++;
      if (f !== F_R) begin errors++; $display("FAIL prio_red: flags=%b expected %b", f, F_R); end
      set_thresholds(8'hFF, 8'h80, 8'h80, 8'h80, 8'h10, 8'h10);
      drive(8'h50, 8'h50, 8'h51);
      checks++;
      if (f !== F_G) begin errors++; $display("FAIL prio_green: flags=%b expected %b", f, F_G); end
      set_thresholds(8'h96, 8'h32, 8'h32, 8'h32, 8'h96, 8'h96);
   endtask
   task automatic test_live_threshold;
      drive(8'h97, 8'h00, 8'h00);
      @(negedge clk);
      r1_code = 8'h97;
      @(posedge clk);
      #1;
      checks++;
      if (f !== F_0) begin errors++; $display("FAIL live_thr: flags=%b expected %b", f, F_0); end
      r1_code = 8'h96;
   endtask
   task automatic test_async_reset;
      drive(8'h97, 8'h00, 8'h00);
      checks++;
      if (f !== F_R) begin errors++; $display("FAIL pre_rst: flags=%b expected %b", f, F_R); end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (f !== F_0) begin errors++; $display("FAIL async_rst: flags=%b expected %b", f, F_0); end
      @(posedge clk);
      #1;
      checks++;
      if (f !== F_0) begin errors++; $display("FAIL rst_held: flags=%b expected %b", f, F_0); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (f !== F_R) begin errors++; $display("FAIL post_rst: flags=%b expected %b", f, F_R); end
   endtask
   task automatic test_hold;
      drive(8'h00, 8'h00, 8'h00);
      for (int i = 1; i <= 4; i++) begin
         drive(8'h97, 8'h00, 8'h00);
         checks++;
         if (f !== ((i == 4) ? F_R : F_0)) begin errors++; $display("FAIL hold_red[%0d]: flags=%b expected %b", i, f, (i == 4) ? F_R : F_0); end
      end
      for (int i = 1; i <= 4; i++) begin
         drive(8'h00, 8'h97, 8'h00);
         checks++;
         if (f !== ((i == 4) ? F_G : F_0)) begin errors++; $display("FAIL hold_green[%0d]: flags=%b expected %b", i, f, (i == 4) ? F_G : F_0); end
      end
      drive(8'h00, 8'h97, 8'h00);
      checks++;
      if (f !== F_G) begin errors++; $display("FAIL hold_sat: flags=%b expected %b", f, F_G); end
   endtask
   initial begin
      test_reset;
`ifdef COLOR_HOLD_EN
      test_hold;
`else
      test_primary;
      test_mixed;
      test_boundary;
      test_no_match;
      test_priority;
      test_live_threshold;
      test_async_reset;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule

// File: doc/color_classifier.md
Name: color_classifier

Overview:
- Clocked RGB colour classifier. Compares an incoming RGB pixel sample against two runtime-programmable threshold code sets.
- Raises one of five colour flags: red, green, blue, purple or yellow.
- Sits after the colour-sensor/pixel front end. Its flags feed downstream sorting/decision logic.
- At most one flag is high in any cycle. Colours that match no class (white, black, orange, greys) assert no flag.

Parameters:
- WIDTH, 8, bit width of each colour channel and each threshold code.
- HOLD_CYCLES, 4, consecutive matching cycles required before a flag asserts; used only when COLOR_HOLD_EN is defined; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- red  output  1  red detected.
- green  output  1  green detected.
- blue  output  1  blue detected.
- purple  output  1  purple detected.
- yellow  output  1  yellow detected.
- r_signal  input  WIDTH  red channel sample.
- g_signal  input  WIDTH  green channel sample.
- b_signal  input  WIDTH  blue channel sample.
- r1_code  input  WIDTH  red "high" threshold (typical 0x96).
- g1_code  input  WIDTH  green "low" threshold (typical 0x32).
- b1_code  input  WIDTH  blue "low" threshold (typical 0x32).
- r2_code  input  WIDTH  red "low" threshold (typical 0x32).
- g2_code  input  WIDTH  green "high" threshold (typical 0x96).
- b2_code  input  WIDTH  blue "high" threshold (typical 0x96).

Behaviour:
- Reset (async, rst=1): all five flags 0 immediately and held at 0 while rst is high. Hold counters (if present) cleared.
- Channel qualifiers (unsigned, combinational on current inputs):
  - R_HI = r_signal > r1_code
  - R_LO = r_signal <= r2_code
  - R_MID = (r_signal > r2_code) and (r_signal <= r1_code)
  - G_HI = g_signal > g2_code
  - G_LO = g_signal <= g1_code
  - B_HI = b_signal > b2_code
  - B_LO = b_signal <= b1_code
- Match terms:
  - red = R_HI & G_LO & B_LO
  - green = G_HI & R_LO & B_LO
  - blue = B_HI & R_LO & G_LO
  - purple = B_HI & R_MID & G_LO
  - yellow = R_HI & G_HI & B_LO
- Comparisons are strict "greater than". A sample equal to a high threshold is NOT high.
- Priority when inconsistent threshold programming lets several terms be true: red > green > blue > purple > yellow. Only the highest-priority flag is asserted, so outputs stay one-hot or all zero.
- Latency: flags are registered; a flag reflects the inputs sampled at the previous rising clk edge (1-cycle latency).
- Threshold inputs are live: a change takes effect on the same edge as a sample change.
- No match: all flags 0.

Optional Feature:
- Macro COLOR_HOLD_EN.
- Defined:
  - One shared 8-bit run counter plus a 3-bit "last class" register.
  - Each cycle the current class equals the previous class: counter increments, saturating at HOLD_CYCLES.
  - Class changes, or no match: counter resets to 1 (0 for no match).
  - A flag asserts only while counter == HOLD_CYCLES and its class matches. Effective assertion latency is HOLD_CYCLES cycles after a stable sample.
  - Flag drops on the first edge after the class changes.
  - Reset clears counter and class.
- Undefined: no counter logic; flags follow the 1-cycle registered path above.

Test Plan:
- Thresholds r1=0x96,g1=0x32,b1=0x32,r2=0x32,g2=0x96,b2=0x96; RGB 0x97/00/00, then 00/97/00, then 00/00/97 -> red, green, blue respectively, one cycle after each sample, others 0.
- RGB 0x33/00/97 -> purple=1; RGB 0x97/97/00 -> yellow=1.
- Boundary: 0x96/00/00, 00/96/00, 00/00/96, 33/00/96, 96/96/00 -> all flags 0 (equality is not "high").
- White FF/FF/FF, black 00/00/00, orange FF/7F/00 -> all flags 0.
- Assert rst mid-sequence with red=1 -> all flags 0 immediately without clk edge; after release, red returns one cycle after next edge.
- COLOR_HOLD_EN, HOLD_CYCLES=4: hold 0x97/00/00 -> red rises on 4th edge; switch to 00/97/00 -> red drops next edge, green rises 4 edges later.
